// File: rtl/echo_pkg.sv
// Shared types for the note echo scheduler: FSM states, rest marker, phrase entry.
// Latency: n/a (types and a helper function only).
// Backpressure: n/a.
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    GAP    = 2'd2,
    PLAY   = 2'd3
  } state_t;

  // Note code stored for a silent stretch inside a phrase.
  localparam logic [3:0] REST = 4'hF;

  // Default duration width; the scheduler builds its own buffer slot from
  // its w_dur parameter, this is the same layout at the default width.
  localparam int W_DUR = 8;

  typedef struct packed {
    logic [3:0]       note;
    logic [W_DUR-1:0] dur;
  } entry_t;

  function automatic logic is_note(input logic [3:0] n);
    return n != REST;
  endfunction

endpackage

// File: rtl/echo_tick_gen.sv
// Free-running prescaler: one-cycle tick pulse every tick_cycles clocks.
// Latency: tick is decoded from the registered count, high on its last value.
// Backpressure: none; runs continuously once out of reset.
//  clk  in   system clock
//  rst  in   synchronous active-high reset, restarts the count at 0
//  tick out  1-cycle pulse
module echo_tick_gen #(
  parameter int tick_cycles = 500000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (tick_cycles > 1) ? $clog2(tick_cycles) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(tick_cycles - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/note_echo_scheduler.sv
// Records a phrase of (note, duration) entries incl. rests, replays it once after gap_ticks of silence.
// Latency: outputs registered; playback starts on the first tick after PLAY is entered, 0-cycle entry changeover.
// Backpressure: none; input is a level, dropped while the buffer is full and throughout PLAY.
//  clk, rst   clock, synchronous active-high reset
//  in_valid   recognizer shows a note; in_note 0..11 (C..B)
//  out_gate   synthesizer should sound; out_note key index
//  state      0 IDLE, 1 RECORD, 2 GAP, 3 PLAY
//  fill       entries stored
module note_echo_scheduler
  import echo_pkg::*;
#(
  parameter int clk_mhz     = 50,
  parameter int tick_ms     = 10,
  parameter int tick_cycles = clk_mhz * 1000 * tick_ms,
  parameter int depth       = 16,
  parameter int w_dur       = 8,
  parameter int gap_ticks   = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [3:0]               in_note,
  output logic                     out_gate,
  output logic [3:0]               out_note,
  output logic [1:0]               state,
  output logic [$clog2(depth):0]   fill
);

  localparam int AW = $clog2(depth);
  localparam int FW = AW + 1;
  localparam logic [w_dur-1:0] DUR_MAX = '1;
  localparam logic [w_dur-1:0] GAP_END = w_dur'(gap_ticks);

  typedef struct packed {
    logic [3:0]       note;
    logic [w_dur-1:0] dur;
  } slot_t;

  logic tick;

  echo_tick_gen #(.tick_cycles(tick_cycles)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Registered state
  state_t           cur_state, st_nxt;
  logic [3:0]       cur_note, note_nxt;
  logic [w_dur-1:0] cur_dur, dur_nxt;
  logic [FW-1:0]    fill_q, fill_nxt;
  logic [FW-1:0]    rd_ptr, rd_nxt;
  logic [w_dur-1:0] play_cnt, cnt_nxt;
  logic             play_on, on_nxt;
  logic             gate_q, gate_nxt;
  logic [3:0]       onote_q, onote_nxt;

  slot_t            mem [depth];
  logic             wr_en;
  slot_t            wr_slot;
  slot_t            rd_slot;

  logic [w_dur-1:0] dur_inc;
  logic [w_dur-1:0] dur_wr;
  logic             wr_last;

  assign dur_inc = (tick && cur_dur != DUR_MAX) ? cur_dur + w_dur'(1) : cur_dur;
  assign dur_wr  = (cur_dur == '0) ? w_dur'(1) : cur_dur;
  assign wr_last = (fill_q == FW'(depth - 1));
  assign rd_slot = mem[rd_ptr[AW-1:0]];

  assign out_gate = gate_q;
  assign out_note = onote_q;
  assign state    = cur_state;
  assign fill     = fill_q;

  always_comb begin
    st_nxt       = cur_state;
    note_nxt     = cur_note;
    dur_nxt      = cur_dur;
    fill_nxt     = fill_q;
    rd_nxt       = rd_ptr;
    cnt_nxt      = play_cnt;
    on_nxt       = play_on;
    gate_nxt     = gate_q;
    onote_nxt    = onote_q;
    wr_en        = 1'b0;
    wr_slot.note = cur_note;
    wr_slot.dur  = dur_wr;

    unique case (cur_state)
      IDLE: begin
        if (in_valid) begin
          st_nxt   = RECORD;
          note_nxt = in_note;
          dur_nxt  = '0;
        end
      end

      RECORD: begin
        if (!in_valid) begin
          wr_en   = 1'b1;
          dur_nxt = '0;
          st_nxt  = wr_last ? PLAY : GAP;
        end else if (in_note != cur_note) begin
          wr_en    = 1'b1;
          note_nxt = in_note;
          dur_nxt  = '0;
          if (wr_last) st_nxt = PLAY;
        end else begin
          dur_nxt = dur_inc;
        end
      end

      GAP: begin
        // Reaching the gap wins over a note arriving in the same cycle.
        if (cur_dur == GAP_END) begin
          st_nxt = PLAY;
        end else if (in_valid) begin
          wr_en        = 1'b1;
          wr_slot.note = REST;
          note_nxt     = in_note;
          dur_nxt      = '0;
          st_nxt       = wr_last ? PLAY : RECORD;
        end else begin
          dur_nxt = dur_inc;
        end
      end

      PLAY: begin
        // The first entry is loaded on a tick so that every entry, the first
        // included, spans a whole number of tick periods.
        if (tick) begin
          if (play_on && play_cnt > w_dur'(1)) begin
            cnt_nxt = play_cnt - w_dur'(1);
          end else if (play_on && rd_ptr == fill_q) begin
            gate_nxt = 1'b0;
            fill_nxt = '0;
            rd_nxt   = '0;
            on_nxt   = 1'b0;
            dur_nxt  = '0;
            st_nxt   = IDLE;
          end else begin
            gate_nxt = is_note(rd_slot.note);
            if (is_note(rd_slot.note)) onote_nxt = rd_slot.note;
            cnt_nxt  = rd_slot.dur;
            rd_nxt   = rd_ptr + FW'(1);
            on_nxt   = 1'b1;
          end
        end
      end

      default: st_nxt = IDLE;
    endcase

    if (wr_en) fill_nxt = fill_q + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= IDLE;
      cur_note  <= '0;
      cur_dur   <= '0;
      fill_q    <= '0;
      rd_ptr    <= '0;
      play_cnt  <= '0;
      play_on   <= 1'b0;
      gate_q    <= 1'b0;
      onote_q   <= '0;
    end else begin
      cur_state <= st_nxt;
      cur_note  <= note_nxt;
      cur_dur   <= dur_nxt;
      fill_q    <= fill_nxt;
      rd_ptr    <= rd_nxt;
      play_cnt  <= cnt_nxt;
      play_on   <= on_nxt;
      gate_q    <= gate_nxt;
      onote_q   <= onote_nxt;
    end
  end

  // Buffer contents need no reset: fill alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[fill_q[AW-1:0]] <= wr_slot;
  end

endmodule
